// File: rtl/pkt_rx_buffer.sv
// Store-and-forward packet buffer: bytes are held until the packet's eop byte
// arrives, then released downstream. Packets longer than DEPTH are dropped.
module pkt_rx_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   input  logic                   in_eop,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic                   out_sop,
   output logic                   out_eop,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] fill_level,
   output logic [$clog2(DEPTH):0] pkt_count,
   output logic                   err_oversize
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

   typedef enum logic {ACCEPT, DISCARD} state_t;

   state_t            state_q, state_d;
   logic [DATA_W:0]   mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       fill_q, fill_d;
   logic [AW:0]       pkt_q, pkt_d;
   logic              err_q, err_d;
   logic              sop_pend_q, sop_pend_d;
   logic              wr_en, pop, pkt_in, pkt_out, drop_all;

   assign in_ready     = (state_q == DISCARD) || (fill_q != FULL);
   assign out_valid    = (pkt_q != '0);
   assign {out_eop, out_data} = mem[rd_ptr_q];
   assign out_sop      = sop_pend_q && out_valid;
   assign fill_level   = fill_q;
   assign pkt_count    = pkt_q;
   assign err_oversize = err_q;

   assign wr_en   = (state_q == ACCEPT) && in_valid && in_ready;
   assign pop     = out_valid && out_ready;
   assign pkt_in  = wr_en && in_eop;
   assign pkt_out = pop && out_eop;
   // A full buffer with no complete packet holds one packet that can never fit.
   assign drop_all = (state_q == ACCEPT) && (fill_q == FULL) && (pkt_q == '0) && !pkt_in;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      pkt_d      = pkt_q;
      err_d      = err_q;
      sop_pend_d = sop_pend_q;

      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + AW'(1);
         sop_pend_d = out_eop;
      end

      case ({wr_en, pop})
         2'b10:   fill_d = fill_q + CW'(1);
         2'b01:   fill_d = fill_q - CW'(1);
         default: fill_d = fill_q;
      endcase

      case ({pkt_in, pkt_out})
         2'b10:   pkt_d = pkt_q + CW'(1);
         2'b01:   pkt_d = pkt_q - CW'(1);
         default: pkt_d = pkt_q;
      endcase

      if (drop_all) begin
         wr_ptr_d = rd_ptr_q;
         fill_d   = '0;
         err_d    = 1'b1;
         state_d  = DISCARD;
      end

      // The eop of the dropped packet re-arms the buffer for the next packet.
      if ((state_q == DISCARD) && in_valid && in_eop) state_d = ACCEPT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ACCEPT;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         pkt_q      <= '0;
         err_q      <= 1'b0;
         sop_pend_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         pkt_q      <= pkt_d;
         err_q      <= err_d;
         sop_pend_q <= sop_pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= {in_eop, in_data};
   end

endmodule

// File: tb/tb_pkt_rx_buffer.sv
// Bench for pkt_rx_buffer: directed scenarios plus random traffic, all checked
// against a queue-based model of the stored bytes.
module tb_pkt_rx_buffer;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_eop = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, out_sop, out_eop, err_oversize;
   logic [DW-1:0] out_data;
   logic [CW-1:0] fill_level, pkt_count;

   int checks = 0;
   int errors = 0;

   // Model: every stored {eop,data} byte in arrival order.
   logic [DW:0] m_q[$];
   bit          m_disc = 1'b0;
   bit          m_err  = 1'b0;
   bit          m_sop  = 1'b1;

   pkt_rx_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_eop(in_eop), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
      .out_ready(out_ready), .fill_level(fill_level), .pkt_count(pkt_count),
      .err_oversize(err_oversize)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic int m_pkts();
      int n = 0;
      foreach (m_q[i]) if (m_q[i][DW]) n++;
      return n;
   endfunction

   function automatic bit m_rdy();
      return m_disc || (m_q.size() < DEPTH);
   endfunction

   // Drive one cycle of inputs, advance the model over the clock edge.
   task automatic tick(input bit v, input logic [DW-1:0] d, input bit e, input bit r);
      int pk;
      bit acc, pop, trig, was_disc;
      in_valid = v; in_data = d; in_eop = e; out_ready = r;
      pk       = m_pkts();
      acc      = v && m_rdy();
      pop      = r && (pk != 0);
      was_disc = m_disc;
      trig     = !m_disc && (m_q.size() == DEPTH) && (pk == 0) && !(acc && e);
      @(posedge clk);
      if (reset) begin
         m_q.delete(); m_disc = 1'b0; m_err = 1'b0; m_sop = 1'b1;
      end else if (trig) begin
         m_q.delete(); m_disc = 1'b1; m_err = 1'b1;
      end else begin
         if (pop) begin
            m_sop = m_q[0][DW];
            void'(m_q.pop_front());
         end
         if (acc && !was_disc) m_q.push_back({e, d});
         if (acc && was_disc && e) m_disc = 1'b0;
      end
      #1;
   endtask

   // Keep presenting a byte until the model says it was taken (bounded).
   task automatic send_byte(input logic [DW-1:0] d, input bit e, input bit r);
      for (int t = 0; t < 8; t++) begin
         bit acc;
         acc = m_rdy();
         tick(1'b1, d, e, r);
         if (acc) return;
      end
      checks++; errors++;
      $display("FAIL send_timeout: byte %h not accepted, got in_ready %b exp 1", d, in_ready);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1'b0, '0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({in_ready, out_valid, fill_level, pkt_count, err_oversize} !== {1'b1, 1'b0, 5'd0, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got rdy%b vld%b fill%0d pkt%0d err%b exp rdy1 vld0 fill0 pkt0 err0",
                  in_ready, out_valid, fill_level, pkt_count, err_oversize);
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] a[3];
      foreach (a[i]) a[i] = DW'($urandom);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: byte %0d got %b exp 0", i, out_valid);
         end
         tick(1'b1, a[i], i == 2, 1'b0);
      end
      checks++;
      if ({out_valid, pkt_count, fill_level} !== {1'b1, 5'd1, 5'd3}) begin
         errors++; $display("FAIL basic_stored: got vld%b pkt%0d fill%0d exp vld1 pkt1 fill3",
                            out_valid, pkt_count, fill_level);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, i == 0, i == 2, a[i]}) begin
            errors++; $display("FAIL basic_head%0d: got v%b s%b e%b %h exp v1 s%b e%b %h",
                               i, out_valid, out_sop, out_eop, out_data, i == 0, i == 2, a[i]);
         end
         tick(1'b0, '0, 1'b0, 1'b1);
      end
      checks++;
      if ({out_valid, pkt_count, fill_level} !== {1'b0, 5'd0, 5'd0}) begin
         errors++; $display("FAIL basic_drained: got vld%b pkt%0d fill%0d exp 0 0 0",
                            out_valid, pkt_count, fill_level);
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < 4; i++) begin
         logic [DW-1:0] d;
         d = 8'h10 + DW'(i);
         tick(1'b1, d, 1'b1, 1'b1);
         checks++;
         if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, 1'b1, 1'b1, d} || pkt_count > 5'd2) begin
            errors++; $display("FAIL single_%0d: got v%b s%b e%b %h pkt%0d exp v1 s1 e1 %h pkt<=2",
                               i, out_valid, out_sop, out_eop, out_data, pkt_count, d);
         end
      end
      tick(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if ({pkt_count, fill_level} !== {5'd0, 5'd0}) begin
         errors++; $display("FAIL single_drained: got pkt%0d fill%0d exp 0 0", pkt_count, fill_level);
      end
   endtask

   task automatic test_full_wrap();
      logic [DW-1:0] d[16];
      foreach (d[i]) d[i] = DW'($urandom);
      for (int i = 0; i < 16; i++) tick(1'b1, d[i], (i == 7) || (i == 15), 1'b0);
      checks++;
      if ({in_ready, fill_level, pkt_count} !== {1'b0, 5'd16, 5'd2}) begin
         errors++; $display("FAIL full_state: got rdy%b fill%0d pkt%0d exp rdy0 fill16 pkt2",
                            in_ready, fill_level, pkt_count);
      end
      tick(1'b1, 8'hEE, 1'b1, 1'b0);
      checks++;
      if ({in_ready, fill_level} !== {1'b0, 5'd16}) begin
         errors++; $display("FAIL full_refuse: got rdy%b fill%0d exp rdy0 fill16", in_ready, fill_level);
      end
      tick(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if ({in_ready, fill_level} !== {1'b1, 5'd15}) begin
         errors++; $display("FAIL full_pop_ready: got rdy%b fill%0d exp rdy1 fill15", in_ready, fill_level);
      end
      for (int i = 1; i < 16; i++) begin
         checks++;
         if ({out_data, out_sop, out_eop} !== {d[i], i == 8, (i == 7) || (i == 15)}) begin
            errors++; $display("FAIL wrap_data%0d: got %h s%b e%b exp %h s%b e%b",
                               i, out_data, out_sop, out_eop, d[i], i == 8, (i == 7) || (i == 15));
         end
         tick(1'b0, '0, 1'b0, 1'b1);
      end
      checks++;
      if (fill_level !== 5'd0) begin
         errors++; $display("FAIL wrap_drained: got fill%0d exp 0", fill_level);
      end
   endtask

   task automatic test_oversize();
      logic [DW-1:0] b1, b2;
      b1 = DW'($urandom); b2 = DW'($urandom);
      for (int i = 0; i < 16; i++) send_byte(DW'($urandom), 1'b0, 1'b1);
      checks++;
      if ({in_ready, fill_level, err_oversize, out_valid} !== {1'b0, 5'd16, 1'b0, 1'b0}) begin
         errors++; $display("FAIL over_full: got rdy%b fill%0d err%b vld%b exp rdy0 fill16 err0 vld0",
                            in_ready, fill_level, err_oversize, out_valid);
      end
      tick(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if ({in_ready, fill_level, err_oversize, pkt_count} !== {1'b1, 5'd0, 1'b1, 5'd0}) begin
         errors++; $display("FAIL over_drop: got rdy%b fill%0d err%b pkt%0d exp rdy1 fill0 err1 pkt0",
                            in_ready, fill_level, err_oversize, pkt_count);
      end
      for (int i = 16; i < 20; i++) begin
         send_byte(DW'($urandom), i == 19, 1'b1);
         checks++;
         if ({fill_level, out_valid} !== {5'd0, 1'b0}) begin
            errors++; $display("FAIL over_discard%0d: got fill%0d vld%b exp fill0 vld0", i, fill_level, out_valid);
         end
      end
      send_byte(b1, 1'b0, 1'b0);
      send_byte(b2, 1'b1, 1'b0);
      checks++;
      if ({pkt_count, fill_level, out_sop, out_data} !== {5'd1, 5'd2, 1'b1, b1}) begin
         errors++; $display("FAIL over_b1: got pkt%0d fill%0d s%b %h exp pkt1 fill2 s1 %h",
                            pkt_count, fill_level, out_sop, out_data, b1);
      end
      tick(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if ({out_sop, out_eop, out_data, err_oversize} !== {1'b0, 1'b1, b2, 1'b1}) begin
         errors++; $display("FAIL over_b2: got s%b e%b %h err%b exp s0 e1 %h err1",
                            out_sop, out_eop, out_data, err_oversize, b2);
      end
      tick(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_simul();
      logic [DW-1:0] p1[3], p2[4];
      foreach (p1[i]) p1[i] = DW'($urandom);
      foreach (p2[i]) p2[i] = DW'($urandom);
      for (int i = 0; i < 3; i++) tick(1'b1, p1[i], i == 2, 1'b0);
      tick(1'b1, p2[0], 1'b0, 1'b0);
      tick(1'b1, p2[1], 1'b0, 1'b1);
      tick(1'b1, p2[2], 1'b0, 1'b1);
      checks++;
      if ({pkt_count, fill_level, out_eop, out_data} !== {5'd1, 5'd4, 1'b1, p1[2]}) begin
         errors++; $display("FAIL simul_pre: got pkt%0d fill%0d e%b %h exp pkt1 fill4 e1 %h",
                            pkt_count, fill_level, out_eop, out_data, p1[2]);
      end
      tick(1'b1, p2[3], 1'b1, 1'b1);
      checks++;
      if ({pkt_count, fill_level, out_sop, out_data} !== {5'd1, 5'd4, 1'b1, p2[0]}) begin
         errors++; $display("FAIL simul_post: got pkt%0d fill%0d s%b %h exp pkt1 fill4 s1 %h",
                            pkt_count, fill_level, out_sop, out_data, p2[0]);
      end
      for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] c0;
      for (int i = 0; i < 5; i++) tick(1'b1, DW'($urandom), i == 2, 1'b0);
      checks++;
      if ({fill_level, pkt_count, err_oversize} !== {5'd5, 5'd1, 1'b1}) begin
         errors++; $display("FAIL rmid_pre: got fill%0d pkt%0d err%b exp fill5 pkt1 err1",
                            fill_level, pkt_count, err_oversize);
      end
      reset = 1'b1;
      tick(1'b1, DW'($urandom), 1'b0, 1'b1);
      reset = 1'b0;
      checks++;
      if ({fill_level, pkt_count, out_valid, err_oversize, in_ready} !== {5'd0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
         errors++; $display("FAIL rmid_post: got fill%0d pkt%0d vld%b err%b rdy%b exp 0 0 0 0 1",
                            fill_level, pkt_count, out_valid, err_oversize, in_ready);
      end
      c0 = DW'($urandom);
      tick(1'b1, c0, 1'b1, 1'b0);
      checks++;
      if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, 1'b1, 1'b1, c0}) begin
         errors++; $display("FAIL rmid_after: got v%b s%b e%b %h exp v1 s1 e1 %h",
                            out_valid, out_sop, out_eop, out_data, c0);
      end
   endtask

   task automatic test_random();
      int rthr = 3;
      for (int cyc = 0; cyc < 900; cyc++) begin
         int pk;
         if (cyc % 100 == 0) rthr = $urandom_range(0, 3);
         pk = m_pkts();
         checks++;
         if ({in_ready, out_valid, fill_level, pkt_count, err_oversize} !==
             {m_rdy(), pk != 0, CW'(m_q.size()), CW'(pk), m_err}) begin
            errors++;
            $display("FAIL rand_status cyc%0d: got rdy%b vld%b fill%0d pkt%0d err%b exp rdy%b vld%b fill%0d pkt%0d err%b",
                     cyc, in_ready, out_valid, fill_level, pkt_count, err_oversize,
                     m_rdy(), pk != 0, m_q.size(), pk, m_err);
         end
         if (pk != 0) begin
            checks++;
            if ({out_sop, out_eop, out_data} !== {m_sop, m_q[0]}) begin
               errors++;
               $display("FAIL rand_head cyc%0d: got s%b e%b %h exp s%b e%b %h",
                        cyc, out_sop, out_eop, out_data, m_sop, m_q[0][DW], m_q[0][DW-1:0]);
            end
         end
         tick($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) <= rthr);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_full_wrap();
      test_oversize();
      test_simul();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pkt_rx_buffer.md
Name: pkt_rx_buffer

Overview:
- Store-and-forward packet buffer directly upstream of dut_top, between the byte-stream source driven through intf and the DUT's packet input port.
- Accepts bytes with an end-of-packet marker over a valid/ready handshake.
- Releases a packet downstream only after its last byte is stored.
- Discards packets too long for the buffer and flags the event.

Parameters:
- DATA_W, 8, data byte width.
- DEPTH, 16, buffer entries (power of 2, >=2); max packet length = DEPTH bytes.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  DATA_W  upstream byte.
- in_eop  input  1  marks last byte of packet.
- in_ready  output  1  buffer can accept a byte this cycle.
- out_valid  output  1  head byte belongs to a complete packet.
- out_data  output  DATA_W  head byte.
- out_sop  output  1  head byte is first byte of a packet.
- out_eop  output  1  head byte is last byte of a packet.
- out_ready  input  1  downstream accepts head byte.
- fill_level  output  $clog2(DEPTH)+1  bytes stored.
- pkt_count  output  $clog2(DEPTH)+1  complete packets stored.
- err_oversize  output  1  sticky: a packet exceeded DEPTH and was dropped.

Behaviour:
- Reset: the following take effect on the first clk edge with reset=1.
  - Pointers, fill_level, pkt_count = 0.
  - err_oversize = 0; FSM = ACCEPT.
  - out_valid = 0; out_sop = 1 (sop_pending); in_ready = 1.
  - Reset mid-packet discards all contents, including partial packets.
- Storage: DEPTH x (DATA_W+1) entries holding {eop, data}. Circular wr_ptr/rd_ptr wrap from DEPTH-1 to 0.
- Write: in ACCEPT, a byte is written when in_valid && in_ready.
- in_ready:
  - In ACCEPT, in_ready = (fill_level < DEPTH).
  - In DISCARD, in_ready = 1.
- Read (pop) when out_valid && out_ready.
- Head outputs:
  - out_valid = (pkt_count != 0).
  - out_data and out_eop are a combinational read of the head entry.
  - out_sop = sop_pending && out_valid.
  - sop_pending is cleared on pop of a non-eop byte and set on pop of an eop byte.
- pkt_count:
  - +1 on a write with in_eop=1.
  - -1 on a pop with out_eop=1.
  - Both in the same cycle: unchanged.
- fill_level: +1 per write, -1 per pop; simultaneous write and pop leaves it unchanged. A write into a full buffer is impossible because in_ready=0.
- Latency: eop byte accepted at edge N, so pkt_count>0 and out_valid=1 in the cycle after N. Minimum 1 cycle from eop acceptance to out_valid. Output throughput is 1 byte/cycle.
- Back-pressure: with out_ready=0, outputs hold stable. in_ready drops only when fill_level==DEPTH.
- FSM ACCEPT -> DISCARD:
  - Trigger: at a clk edge where fill_level==DEPTH and pkt_count==0. The whole buffer is then one partial packet and can never complete.
  - Actions: wr_ptr <= rd_ptr, fill_level <= 0, err_oversize <= 1.
  - If an eop byte is written on that same edge, it completes the packet instead and no discard occurs.
- FSM DISCARD:
  - Input bytes are accepted and dropped; nothing is written.
  - On an accepted byte with in_eop=1, FSM returns to ACCEPT. The next byte starts a fresh packet.
- A partial packet behind complete packets is kept. Input stalls until pops free space.
- Single-byte packets: the byte has sop and eop both set. out_sop=1 and out_eop=1 in the same cycle.
- err_oversize clears only on reset.

Test Plan:
- Reset, then write 3-byte packet A1,A2,A3(eop) with out_ready=0. Required:
  - out_valid=0 until the cycle after A3 is accepted.
  - pkt_count=1, fill_level=3.
  - With out_ready=1: A1 sop=1, A2, A3 eop=1 on consecutive cycles.
  - Afterwards pkt_count=0, fill_level=0.
- Write 4 single-byte packets 0x10..0x13, each with eop, while out_ready=1. Each byte is emitted with sop=1 and eop=1 in order. pkt_count never exceeds 2.
- Fill with two 8-byte packets (DEPTH=16), out_ready=0. Required:
  - in_ready=0 at fill_level=16.
  - One pop raises in_ready the following cycle.
  - Wrap-around data integrity holds across pointer 15->0.
- Drive a 20-byte packet with no eop until the 20th byte. Required:
  - After 16 bytes: err_oversize=1, fill_level=0, FSM in DISCARD.
  - Bytes 17-20 are accepted and dropped.
  - A following 2-byte packet B1,B2 emerges intact.
- Simultaneous events: write the eop of packet 2 in the same cycle as popping the eop of packet 1. pkt_count stays 1 and fill_level updates correctly.
- Assert reset for one cycle mid-packet, with 5 bytes stored and 1 complete packet. Next cycle: fill_level=0, pkt_count=0, out_valid=0, err_oversize=0, in_ready=1.
